// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: central pipeline sequencer.
// Merges the hazard stall request, the taken-branch flush and the data-memory
// busy freeze into one prioritised FSM, MEM_BUSY > FLUSH > BRANCH > HAZARD.
// Outputs are Mealy: they follow the inputs in the same cycle.
// Optional feature: define PIPE_WATCHDOG_EN to build the MEM_WAIT watchdog.
// Without it, WDOG_TIMEOUT is tied to 0.
//
// Handshake: MEM_BUSY is a level-sensitive "not ready" from data memory.
// Each cycle it is high, every register from ID_EXE onward holds (PIPE_FREEZE=1).
// The frozen MEM access completes on the first edge that samples MEM_BUSY=0.
// No other request is accepted while MEM_BUSY is high.
module pipeline_stall_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16,
  parameter int WDOG_LIMIT   = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             HAZARD_DETECTED,
  input  logic             BRANCH_TAKEN,
  input  logic             MEM_BUSY,
  output logic             PC_WRITE_EN,
  output logic             IF_ID_WRITE_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EXE_BUBBLE,
  output logic             PIPE_FREEZE,
  output logic [CNT_W-1:0] STALL_COUNT,
  output logic             WDOG_TIMEOUT,
  output logic [1:0]       DBG_STATE
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Reject parameter values the flush counter or watchdog cannot represent.
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || WDOG_LIMIT < 1 || WDOG_LIMIT > 255) begin : g_param_check
    $error("pipeline_stall_ctrl: parameter out of range");
  end

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t           r_state, w_state_next;
  state_t           r_ret_state, w_ret_state_next;
  logic [2:0]       r_flush_cnt, w_flush_cnt_next;
  logic [CNT_W-1:0] r_stall_cnt;
  state_t           w_eff_state;

  // A MEM_WAIT cycle with memory ready is handled as the state it interrupted.
  assign w_eff_state = (r_state == MEM_WAIT) ? r_ret_state : r_state;

  // FSM, return-state and flush-counter registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= RUN;
      r_ret_state <= RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_ret_state <= w_ret_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  // Next-state and Mealy output decode in priority order.
  always_comb begin
    w_state_next     = r_state;
    w_ret_state_next = r_ret_state;
    w_flush_cnt_next = r_flush_cnt;
    PC_WRITE_EN      = 1'b0;
    IF_ID_WRITE_EN   = 1'b0;
    IF_ID_FLUSH      = 1'b0;
    ID_EXE_BUBBLE    = 1'b0;
    PIPE_FREEZE      = 1'b0;
    if (!RST_N) begin
      // Inject NOPs into IF_ID and ID_EXE while reset is held.
      IF_ID_FLUSH   = 1'b1;
      ID_EXE_BUBBLE = 1'b1;
    end else if (MEM_BUSY) begin
      // Freeze everything. Remember where to resume; the flush counter holds.
      PIPE_FREEZE  = 1'b1;
      w_state_next = MEM_WAIT;
      if (r_state != MEM_WAIT) w_ret_state_next = r_state;
    end else begin
      unique case (w_eff_state)
        FLUSH: begin
          // Wrong-path slots: keep fetching and flushing. Branch and hazard are ignored.
          PC_WRITE_EN    = 1'b1;
          IF_ID_WRITE_EN = 1'b1;
          IF_ID_FLUSH    = 1'b1;
          w_flush_cnt_next = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_flush_cnt_next = 3'd0;
            w_state_next     = RUN;
          end else begin
            w_state_next = FLUSH;
          end
        end
        default: begin
          w_state_next = RUN;
          if (BRANCH_TAKEN) begin
            PC_WRITE_EN    = 1'b1;
            IF_ID_WRITE_EN = 1'b1;
            IF_ID_FLUSH    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_next     = FLUSH;
              w_flush_cnt_next = FLUSH_RELOAD;
            end
          end else if (HAZARD_DETECTED) begin
            ID_EXE_BUBBLE = 1'b1;
          end else begin
            PC_WRITE_EN    = 1'b1;
            IF_ID_WRITE_EN = 1'b1;
          end
        end
      endcase
    end
  end

  // Saturating count of cycles spent frozen or bubbling.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stall_cnt <= '0;
    end else if ((PIPE_FREEZE || ID_EXE_BUBBLE) && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign STALL_COUNT = r_stall_cnt;
  assign DBG_STATE   = r_state;

`ifdef PIPE_WATCHDOG_EN
  logic [7:0] r_wdog_cnt;
  logic [7:0] w_wdog_inc;
  logic       r_wdog;

  assign w_wdog_inc = (r_wdog_cnt == 8'hFF) ? 8'hFF : r_wdog_cnt + 8'd1;

  // Count consecutive busy cycles. The flag is sticky and only reports; it never unfreezes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wdog_cnt <= 8'd0;
      r_wdog     <= 1'b0;
    end else if (MEM_BUSY) begin
      r_wdog_cnt <= w_wdog_inc;
      if (w_wdog_inc >= 8'(WDOG_LIMIT)) r_wdog <= 1'b1;
    end else begin
      r_wdog_cnt <= 8'd0;
    end
  end

  assign WDOG_TIMEOUT = r_wdog;
`else
  assign WDOG_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (FLUSH_CYCLES=3, CNT_W=4, WDOG_LIMIT=10).
// Each step drives the inputs and queues the expected output vector
// {PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EXE_BUBBLE, PIPE_FREEZE}.
// The vector is compared at the following falling edge.
module tb_pipeline_stall_ctrl;
  localparam int W     = 5;
  localparam int CNT_W = 4;

  localparam logic [W-1:0] V_RUN   = 5'b11000;
  localparam logic [W-1:0] V_HAZ   = 5'b00010;
  localparam logic [W-1:0] V_FLUSH = 5'b11100;
  localparam logic [W-1:0] V_FRZ   = 5'b00001;
  localparam logic [W-1:0] V_RST   = 5'b00110;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             HAZARD_DETECTED, BRANCH_TAKEN, MEM_BUSY;
  logic             PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EXE_BUBBLE, PIPE_FREEZE;
  logic [CNT_W-1:0] STALL_COUNT;
  logic             WDOG_TIMEOUT;
  logic [1:0]       DBG_STATE;

  logic [W-1:0]     exp_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic             exp_wdog = 1'b0;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(3), .CNT_W(CNT_W), .WDOG_LIMIT(10)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .HAZARD_DETECTED(HAZARD_DETECTED), .BRANCH_TAKEN(BRANCH_TAKEN), .MEM_BUSY(MEM_BUSY),
    .PC_WRITE_EN(PC_WRITE_EN), .IF_ID_WRITE_EN(IF_ID_WRITE_EN), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EXE_BUBBLE(ID_EXE_BUBBLE), .PIPE_FREEZE(PIPE_FREEZE),
    .STALL_COUNT(STALL_COUNT), .WDOG_TIMEOUT(WDOG_TIMEOUT), .DBG_STATE(DBG_STATE)
  );

  // Clock and reset
  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] outs();
    return {PC_WRITE_EN, IF_ID_WRITE_EN, IF_ID_FLUSH, ID_EXE_BUBBLE, PIPE_FREEZE};
  endfunction

  task automatic check_cnt(input string tag);
    vectors++;
    assert (STALL_COUNT === exp_stall) else begin
      miscompares++;
      $error("FAIL %s stall_count got=%0d exp=%0d", tag, STALL_COUNT, exp_stall);
    end
    vectors++;
    assert (WDOG_TIMEOUT === exp_wdog) else begin
      miscompares++;
      $error("FAIL %s wdog got=%0b exp=%0b", tag, WDOG_TIMEOUT, exp_wdog);
    end
  endtask

  // Driver: one cycle of stimulus, scoreboard pop at the falling edge.
  task automatic step(input string tag, input logic hz, input logic br, input logic mb,
                      input logic [W-1:0] exp);
    logic [W-1:0] e;
    logic [W-1:0] got;
    HAZARD_DETECTED = hz;
    BRANCH_TAKEN    = br;
    MEM_BUSY        = mb;
    exp_q.push_back(exp);
    @(negedge CLK);
    got = outs();
    e   = exp_q.pop_front();
    vectors++;
    assert (got === e) else begin
      miscompares++;
      $error("FAIL %s outs got=%b exp=%b", tag, got, e);
    end
    check_cnt(tag);
    if ((e[1] || e[0]) && exp_stall != {CNT_W{1'b1}}) exp_stall = exp_stall + 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset in mid-cycle; checks the outputs while reset is held.
  task automatic mid_reset(input string tag);
    logic [W-1:0] got;
    HAZARD_DETECTED = 1'b0;
    BRANCH_TAKEN    = 1'b0;
    MEM_BUSY        = 1'b0;
    #2;
    RST_N = 1'b0;
    #1;
    exp_stall = '0;
    exp_wdog  = 1'b0;
    got = outs();
    vectors++;
    assert (got === V_RST) else begin
      miscompares++;
      $error("FAIL %s outs got=%b exp=%b", tag, got, V_RST);
    end
    check_cnt(tag);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0;
    HAZARD_DETECTED = 1'b0;
    BRANCH_TAKEN    = 1'b0;
    MEM_BUSY        = 1'b0;
    #3;
    begin
      logic [W-1:0] got;
      got = outs();
      vectors++;
      assert (got === V_RST) else begin
        miscompares++;
        $error("FAIL reset outs got=%b exp=%b", got, V_RST);
      end
      check_cnt("reset");
    end
    #9;
    RST_N = 1'b1;

    // Idle after reset release
    step("idle0", 0, 0, 0, V_RUN);

    // Hazard for three cycles, then back to normal
    for (int i = 0; i < 3; i++) step("hazard", 1, 0, 0, V_HAZ);
    step("post_hazard", 0, 0, 0, V_RUN);

    // Taken branch: three flush cycles; a hazard in flush cycle 2 is ignored
    step("br_flush1", 0, 1, 0, V_FLUSH);
    step("br_flush2", 1, 0, 0, V_FLUSH);
    step("br_flush3", 0, 0, 0, V_FLUSH);
    step("br_done", 0, 0, 0, V_RUN);

    // Memory busy for 4 cycles from flush cycle 2; the flush resumes afterwards
    step("mb_flush1", 0, 1, 0, V_FLUSH);
    for (int i = 0; i < 4; i++) step("mb_freeze", 0, 1, 1, V_FRZ);
    step("mb_flush2", 0, 0, 0, V_FLUSH);
    step("mb_flush3", 0, 0, 0, V_FLUSH);
    step("mb_done", 0, 0, 0, V_RUN);

    // All requests together: only the freeze; the branch is re-presented next cycle
    step("all_high", 1, 1, 1, V_FRZ);
    step("re_branch", 0, 1, 0, V_FLUSH);
    step("re_flush2", 0, 0, 0, V_FLUSH);
    step("re_flush3", 0, 0, 0, V_FLUSH);

    // Branch and hazard together in RUN: the branch wins
    step("br_hz", 1, 1, 0, V_FLUSH);
    step("br_hz_f2", 1, 0, 0, V_FLUSH);
    step("br_hz_f3", 1, 0, 0, V_FLUSH);
    step("br_hz_run", 1, 0, 0, V_HAZ);

    // Memory wait from RUN returns to RUN and accepts a hazard
    step("mw_run", 0, 0, 1, V_FRZ);
    step("mw_ret_haz", 1, 0, 0, V_HAZ);
    step("mw_ret_run", 0, 0, 0, V_RUN);

    // Stall counter saturation
    for (int i = 0; i < 8; i++) step("sat", 1, 0, 0, V_HAZ);
    step("sat_idle", 0, 0, 0, V_RUN);

    // Reset in the middle of a flush abandons it
    step("pre_rst_br", 0, 1, 0, V_FLUSH);
    mid_reset("mid_rst_flush");
    step("post_rst", 0, 0, 0, V_RUN);

    // Long memory wait: the watchdog trips after 10 busy cycles
    for (int k = 1; k <= 12; k++) begin
`ifdef PIPE_WATCHDOG_EN
      if (k >= 11) exp_wdog = 1'b1;
`endif
      step("wdog_busy", 0, 0, 1, V_FRZ);
    end
`ifdef PIPE_WATCHDOG_EN
    exp_wdog = 1'b1;
`endif
    step("wdog_sticky", 0, 0, 0, V_RUN);
    step("wdog_sticky2", 0, 0, 0, V_RUN);
    mid_reset("wdog_rst");
    step("wdog_cleared", 0, 0, 0, V_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
